e1000_dma_rd_arbiter: RTL and testbench
=======================================

// Module: e1000_dma_rd_arbiter
// PURPOSE
//  Shares the single AXI4 DMA read channel (AR/R) in front of grpci2_axi_mst among NUM_REQ
//  read requesters inside the NIC (descriptor fetch, TX data fetch, ...).
//  - Round-robin arbitration on AR; per-requester outstanding-burst limit.
//  - Tags ARID with the requester index and routes R beats back by RID.
//  - Requesters issue only 32-bit INCR bursts, so size/burst/cache are fixed on the master side.
// PARAMETERS
//  NUM_REQ      2  number of requesters, 1..4 (index carried in ARID[1:0])
//  MAX_OUTST    4  max outstanding bursts per requester, 1..15
// PORTS
//  aclk       in   1        clock
//  rstni      in   1        reset, asynchronous, active-low
//  s_arvalid  in   NUM_REQ  per-requester AR valid
//  s_arready  out  NUM_REQ  per-requester AR ready (grant), at most one bit set
//  s_araddr   in   NUM_REQ*64  per-requester address, requester i at [64*i+:64]
//  s_arlen    in   NUM_REQ*8   per-requester burst length-1, requester i at [8*i+:8]
//  s_rvalid   out  NUM_REQ  per-requester R valid
//  s_rready   in   NUM_REQ  per-requester R ready
//  s_rdata    out  32       R data, broadcast to all requesters
//  s_rresp    out  2        R resp, broadcast
//  s_rlast    out  1        R last, broadcast
//  m_arid     out  4        {2'b00, requester index}
//  m_araddr   out  64       registered address
//  m_arlen    out  8        registered length
//  m_arsize   out  3        constant 3'b010
//  m_arburst  out  2        constant 2'b01 (INCR)
//  m_arcache  out  4        constant 4'b0011
//  m_arvalid  out  1        AR valid to DMA master
//  m_arready  in   1        AR ready from DMA master
//  m_rid      in   4        R id
//  m_rdata    in   32       R data
//  m_rresp    in   2        R resp
//  m_rlast    in   1        R last
//  m_rvalid   in   1        R valid
//  m_rready   out  1        R ready
//  rid_err    out  1        one-cycle pulse: R beat with unknown RID was dropped
// BEHAVIOUR
//  Reset:
//   - m_arvalid=0; m_arid/m_araddr/m_arlen=0; rid_err=0.
//   - RR pointer=0; all outstanding counters=0.
//  AR arbitration:
//   - AR register is free when !m_arvalid || m_arready.
//   - Eligible(i) = s_arvalid[i] && outst[i] < MAX_OUTST.
//   - In a free cycle, the first eligible requester at or after the RR pointer (modulo NUM_REQ)
//     gets combinational s_arready[i]=1. No eligible requester -> no grant.
//   - Grant edge: payload loads into m_* and m_arvalid=1; RR pointer <= (i+1) mod NUM_REQ.
//   - Latency: 1 cycle from s-accept to m_arvalid. Throughput: 1 AR/cycle while m_arready=1.
//   - m_ar* stays stable while m_arvalid && !m_arready (AXI rule).
//   - s_arready never asserts combinationally from s_arvalid alone when the register is full.
//  R routing (combinational, zero latency):
//   - idx = m_rid[1:0].
//   - Valid index (m_rid[3:2]==0 && idx<NUM_REQ): s_rvalid[idx]=m_rvalid, others 0;
//     m_rready = s_rready[idx].
//   - Invalid index: all s_rvalid=0, m_rready=1 (beat dropped), rid_err pulses next cycle.
//  Outstanding counters (4 bits each):
//   - +1 on requester i AR accept (s_arvalid[i]&&s_arready[i]).
//   - -1 on m_rvalid&&m_rready&&m_rlast with valid idx==i.
//   - Increment and decrement in the same cycle -> unchanged.
//   - Decrement at 0 is ignored (counter saturates; no wrap). Increment at MAX_OUTST cannot
//     occur because eligibility blocks it.
//  Ordering: per-requester R data returns in AR order; inter-requester interleave follows RID.
//  rstni deassertion mid-burst: all state cleared; in-flight R beats after reset route by RID
//  normally (counters stay at 0).
// TESTING
//  1. Reset, NUM_REQ=2, both s_arvalid=1, m_arready=1 -> grants alternate 0,1,0,1;
//     m_arid=0,1,0,1; m_arvalid one cycle after each grant.
//  2. Req0 only, MAX_OUTST=4, no R returned -> exactly 4 ARs accepted, 5th stalls; one rlast
//     for RID 0 -> 5th accepted the next cycle.
//  3. m_arready=0 for 10 cycles with m_arvalid=1 -> m_araddr/m_arlen/m_arid constant,
//     s_arready=0 throughout.
//  4. m_rvalid=1, m_rid=1, s_rready[1]=0 for 3 cycles -> s_rvalid=2'b10, m_rready=0;
//     beat completes on the cycle s_rready[1]=1.
//  5. m_rid=4'h7, m_rvalid=1 -> m_rready=1, s_rvalid=0, rid_err=1 on the next cycle only,
//     counters unchanged.
//  6. Same-cycle AR accept and rlast for req0 with outst=2 -> outst stays 2; rstni pulse
//     mid-stream -> m_arvalid=0 and counters 0 within the reset.

Source files
------------

// File: rtl/e1000_dma_rd_arbiter.sv
// rtl/e1000_dma_rd_arbiter.sv - round-robin AXI4 read-channel arbiter with RID-tagged R routing
// Requester index travels in ARID[1:0]; R beats are steered back by RID with zero latency.
module e1000_dma_rd_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_OUTST = 4
) (
    input  logic                   aclk,
    input  logic                   rstni,
    input  logic [NUM_REQ-1:0]     s_arvalid,
    output logic [NUM_REQ-1:0]     s_arready,
    input  logic [NUM_REQ*64-1:0]  s_araddr,
    input  logic [NUM_REQ*8-1:0]   s_arlen,
    output logic [NUM_REQ-1:0]     s_rvalid,
    input  logic [NUM_REQ-1:0]     s_rready,
    output logic [31:0]            s_rdata,
    output logic [1:0]             s_rresp,
    output logic                   s_rlast,
    output logic [3:0]             m_arid,
    output logic [63:0]            m_araddr,
    output logic [7:0]             m_arlen,
    output logic [2:0]             m_arsize,
    output logic [1:0]             m_arburst,
    output logic [3:0]             m_arcache,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [3:0]             m_rid,
    input  logic [31:0]            m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rlast,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic                   rid_err
);

    logic         r_arvalid;
    logic [3:0]   r_arid;
    logic [63:0]  r_araddr;
    logic [7:0]   r_arlen;
    logic [1:0]   r_rr_ptr;
    logic [3:0]   r_outst [NUM_REQ];
    logic         r_rid_err;

    logic         w_free;
    logic         w_gnt_any;
    logic [1:0]   w_gnt_idx;
    logic [2:0]   w_nxt_ptr;
    logic [3:0]   w_elig4;
    logic [3:0]   w_rready4;
    logic [63:0]  w_addr_a [4];
    logic [7:0]   w_len_a [4];
    logic         w_rid_ok;
    logic         w_m_rready;
    logic         w_rlast_hs;
    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;

    // Requester-indexed views padded to 4 entries so 2-bit indices always fit.
    always_comb begin
        w_elig4   = '0;
        w_rready4 = '0;
        for (int i = 0; i < 4; i++) begin
            w_addr_a[i] = '0;
            w_len_a[i]  = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig4[i]   = s_arvalid[i] && (r_outst[i] < 4'(MAX_OUTST));
            w_rready4[i] = s_rready[i];
            w_addr_a[i]  = s_araddr[64*i +: 64];
            w_len_a[i]   = s_arlen[8*i +: 8];
        end
    end

    always_comb begin
        logic [2:0] w_cand;
        w_free    = !r_arvalid || m_arready;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + 3'(k);
            if (w_cand >= 3'(NUM_REQ))
                w_cand = w_cand - 3'(NUM_REQ);
            if (w_free && !w_gnt_any && w_elig4[w_cand[1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[1:0];
            end
        end
        w_nxt_ptr = {1'b0, w_gnt_idx} + 3'd1;
        if (w_nxt_ptr >= 3'(NUM_REQ))
            w_nxt_ptr = '0;
    end

    // Unknown RIDs are swallowed (ready forced high) so the DMA master never stalls.
    always_comb begin
        w_rid_ok   = (m_rid[3:2] == 2'b00) && ({1'b0, m_rid[1:0]} < 3'(NUM_REQ));
        w_m_rready = w_rid_ok ? w_rready4[m_rid[1:0]] : 1'b1;
        w_rlast_hs = m_rvalid && w_m_rready && m_rlast && w_rid_ok;
        for (int i = 0; i < NUM_REQ; i++) begin
            s_arready[i] = w_gnt_any && (w_gnt_idx == 2'(i));
            s_rvalid[i]  = m_rvalid && w_rid_ok && (m_rid[1:0] == 2'(i));
            w_inc[i]     = w_gnt_any && (w_gnt_idx == 2'(i));
            w_dec[i]     = w_rlast_hs && (m_rid[1:0] == 2'(i));
        end
    end

    always_ff @(posedge aclk or negedge rstni) begin
        if (!rstni) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_rr_ptr  <= '0;
            r_rid_err <= 1'b0;
        end else begin
            r_rid_err <= m_rvalid && !w_rid_ok;
            if (w_gnt_any) begin
                r_arvalid <= 1'b1;
                r_arid    <= {2'b00, w_gnt_idx};
                r_araddr  <= w_addr_a[w_gnt_idx];
                r_arlen   <= w_len_a[w_gnt_idx];
                r_rr_ptr  <= w_nxt_ptr[1:0];
            end else if (m_arready) begin
                r_arvalid <= 1'b0;
            end
        end
    end

    // Decrement at zero is ignored so stale beats after a reset cannot wrap a counter.
    always_ff @(posedge aclk or negedge rstni) begin
        if (!rstni) begin
            for (int i = 0; i < NUM_REQ; i++)
                r_outst[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_outst[i] <= r_outst[i] + 4'd1;
                else if (!w_inc[i] && w_dec[i] && (r_outst[i] != 4'd0))
                    r_outst[i] <= r_outst[i] - 4'd1;
            end
        end
    end

    assign m_arvalid = r_arvalid;
    assign m_arid    = r_arid;
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_arcache = 4'b0011;
    assign m_rready  = w_m_rready;
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign rid_err   = r_rid_err;

endmodule

// File: tb/tb_e1000_dma_rd_arbiter.sv
// tb/tb_e1000_dma_rd_arbiter.sv - scoreboard bench for e1000_dma_rd_arbiter
module tb_e1000_dma_rd_arbiter;
    localparam int NUM_REQ   = 2;
    localparam int MAX_OUTST = 4;

    logic aclk = 1'b0;
    logic rstni = 1'b0;
    always #5 aclk = ~aclk;

    logic [NUM_REQ-1:0]    s_arvalid = '0;
    logic [NUM_REQ-1:0]    s_arready;
    logic [NUM_REQ*64-1:0] s_araddr = '0;
    logic [NUM_REQ*8-1:0]  s_arlen = '0;
    logic [NUM_REQ-1:0]    s_rvalid;
    logic [NUM_REQ-1:0]    s_rready = '0;
    logic [31:0]           s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rlast;
    logic [3:0]            m_arid;
    logic [63:0]           m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic [3:0]            m_arcache;
    logic                  m_arvalid;
    logic                  m_arready = 1'b0;
    logic [3:0]            m_rid = '0;
    logic [31:0]           m_rdata = '0;
    logic [1:0]            m_rresp = '0;
    logic                  m_rlast = 1'b0;
    logic                  m_rvalid = 1'b0;
    logic                  m_rready;
    logic                  rid_err;

    e1000_dma_rd_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTST(MAX_OUTST)) dut (
        .aclk(aclk), .rstni(rstni),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arcache(m_arcache),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .rid_err(rid_err)
    );

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] srv;
        logic       mrdy;
        logic       arv;
        logic       rerr;
    } cyc_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    cyc_t cyc_q[$];
    ar_t  ar_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mdl_ptr = 0;
    int   mdl_cnt [NUM_REQ];
    logic mdl_arv = 1'b0;
    logic prev_bad = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: first eligible requester scanning from the pointer, counters as plain ints.
    task automatic cyc(input logic rst, input logic [1:0] arv, input logic ardy, input logic rv,
                       input logic [3:0] rid, input logic rl, input logic [1:0] rrdy);
        int   g;
        logic free;
        logic ok;
        logic mrdy;
        cyc_t r;
        @(posedge aclk);
        #2;
        rstni     = rst;
        s_arvalid = arv;
        s_araddr  = {$urandom, $urandom, $urandom, $urandom};
        s_arlen   = {8'($urandom), 8'($urandom)};
        m_arready = ardy;
        m_rvalid  = rv;
        m_rid     = rid;
        m_rlast   = rl;
        s_rready  = rrdy;
        m_rdata   = $urandom;
        m_rresp   = 2'($urandom);
        if (!rst) begin
            mdl_ptr = 0;
            foreach (mdl_cnt[i]) mdl_cnt[i] = 0;
            mdl_arv  = 1'b0;
            prev_bad = 1'b0;
            ar_q.delete();
        end
        free = !mdl_arv || ardy;
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (mdl_ptr + k) % NUM_REQ;
            if (g < 0 && free && arv[j] && mdl_cnt[j] < MAX_OUTST) g = j;
        end
        ok   = (rid[3:2] == 2'b00) && (int'(rid[1:0]) < NUM_REQ);
        mrdy = ok ? rrdy[rid[0]] : 1'b1;
        r.gnt  = (g >= 0) ? 2'(1 << g) : 2'b00;
        r.srv  = (ok && rv) ? 2'(1 << rid[1:0]) : 2'b00;
        r.mrdy = mrdy;
        r.arv  = mdl_arv;
        r.rerr = prev_bad;
        cyc_q.push_back(r);
        if (rst) begin
            if (g >= 0) begin
                ar_q.push_back({4'(g), s_araddr[64*g +: 64], s_arlen[8*g +: 8]});
                mdl_cnt[g]++;
                mdl_ptr = (g + 1) % NUM_REQ;
            end
            if (rv && mrdy && rl && ok && mdl_cnt[rid[0]] > 0) mdl_cnt[rid[0]]--;
            mdl_arv  = (g >= 0) || (mdl_arv && !ardy);
            prev_bad = rv && !ok;
        end
    endtask

    initial begin : monitor
        cyc_t e;
        ar_t  a;
        forever begin
            @(negedge aclk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("s_arready", 64'(s_arready), 64'(e.gnt));
                chk("s_rvalid", 64'(s_rvalid), 64'(e.srv));
                chk("m_rready", 64'(m_rready), 64'(e.mrdy));
                chk("m_arvalid", 64'(m_arvalid), 64'(e.arv));
                chk("rid_err", 64'(rid_err), 64'(e.rerr));
                chk("s_rdata", 64'(s_rdata), 64'(m_rdata));
                chk("s_rlast", 64'(s_rlast), 64'(m_rlast));
                if (m_arvalid && m_arready) begin
                    if (ar_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL ar_handshake: got unexpected AR id %0h expected none", m_arid);
                    end else begin
                        a = ar_q.pop_front();
                        chk("m_arid", 64'(m_arid), 64'(a.id));
                        chk("m_araddr", m_araddr, a.addr);
                        chk("m_arlen", 64'(m_arlen), 64'(a.len));
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [3:0] rids [6];
        rids = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7};
        foreach (mdl_cnt[i]) mdl_cnt[i] = 0;
        // arguments: rst, arvalid, arready, rvalid, rid, rlast, rready
        repeat (2) cyc(0, 2'b00, 0, 0, 4'h0, 0, 2'b00);
        repeat (6) cyc(1, 2'b11, 1, 0, 4'h0, 0, 2'b00);
        repeat (10) cyc(1, 2'b11, 0, 0, 4'h0, 0, 2'b00);
        repeat (2) cyc(1, 2'b00, 1, 0, 4'h0, 0, 2'b00);
        repeat (2) cyc(0, 2'b00, 0, 0, 4'h0, 0, 2'b00);
        repeat (6) cyc(1, 2'b01, 1, 0, 4'h0, 0, 2'b00);
        cyc(1, 2'b01, 1, 1, 4'h0, 1, 2'b01);
        repeat (2) cyc(1, 2'b01, 1, 0, 4'h0, 0, 2'b00);
        repeat (3) cyc(1, 2'b00, 1, 1, 4'h1, 0, 2'b00);
        cyc(1, 2'b00, 1, 1, 4'h1, 0, 2'b10);
        cyc(1, 2'b00, 1, 1, 4'h7, 1, 2'b11);
        repeat (2) cyc(1, 2'b00, 1, 0, 4'h0, 0, 2'b11);
        repeat (2) cyc(0, 2'b00, 0, 0, 4'h0, 0, 2'b00);
        repeat (2) cyc(1, 2'b01, 1, 0, 4'h0, 0, 2'b00);
        cyc(1, 2'b01, 1, 1, 4'h0, 1, 2'b01);
        repeat (6) cyc(1, 2'b01, 1, 0, 4'h0, 0, 2'b00);
        for (int n = 0; n < 600; n++) begin
            cyc((n % 250) < 2 ? 1'b0 : 1'b1, 2'($urandom), ($urandom_range(0, 9) < 7),
                1'($urandom), rids[$urandom_range(0, 5)], 1'($urandom), 2'($urandom));
        end
        repeat (3) cyc(1, 2'b00, 1, 0, 4'h0, 0, 2'b00);
        @(negedge aclk);
        @(negedge aclk);
        chk("pending_cycles", 64'(cyc_q.size()), 64'd0);
        chk("pending_ar", 64'(ar_q.size()), 64'd0);
        chk("m_arsize", 64'(m_arsize), 64'h2);
        chk("m_arburst", 64'(m_arburst), 64'h1);
        chk("m_arcache", 64'(m_arcache), 64'h3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
